// File: rtl/add_resp_pipe.sv
// rtl/add_resp_pipe.sv - two-operand adder with one stage register and credit-guarded result FIFO
//
// Purpose:
//   Accepts operand pairs on a valid/ready input, registers them in a single
//   stage (s1), and writes {sum, carry, overflow} into a small result FIFO.
//   Results leave through a valid/ready output in acceptance order.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand transaction valid
//   in_ready   block can accept an operand transaction
//   in_a/in_b  operands, DATA_WIDTH bits each
//   out_valid  FIFO head holds a result
//   out_ready  consumer accepts the head result
//   out_sum    (a+b) mod 2^DATA_WIDTH
//   out_carry  unsigned carry-out
//   out_ovf    two's-complement signed overflow
//   occupancy  FIFO entry count (stage register not included)
//   txn_count  completed output handshakes, wrapping

module add_resp_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_a,
    input  logic [DATA_WIDTH-1:0]         in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_sum,
    output logic                          out_carry,
    output logic                          out_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy,
    output logic [CNT_WIDTH-1:0]          txn_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = AW + 1;
    localparam int WW = DATA_WIDTH + 2;
    localparam logic [OW:0] DEPTH_L = (OW+1)'(FIFO_DEPTH);

    // Stage register
    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_a;
    logic [DATA_WIDTH-1:0] r_s1_b;

    // Result FIFO: word = {ovf, carry, sum}
    logic [WW-1:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [OW-1:0]         r_occ;
    logic [CNT_WIDTH-1:0]  r_txn;

    logic [DATA_WIDTH:0]   w_full_sum;
    logic                  w_ovf;
    logic [WW-1:0]         w_wr_word;
    logic [WW-1:0]         w_head;
    logic [OW:0]           w_used;
    logic                  w_accept;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_nonempty;

    assign w_full_sum = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    // Signed overflow: operands share a sign that the truncated sum does not.
    assign w_ovf      = (r_s1_a[DATA_WIDTH-1] == r_s1_b[DATA_WIDTH-1]) &&
                        (w_full_sum[DATA_WIDTH-1] != r_s1_a[DATA_WIDTH-1]);
    assign w_wr_word  = {w_ovf, w_full_sum};

    // Credits count the stage register as well as the FIFO, so whatever sits
    // in s1 always has a free slot waiting for it and s1 never stalls. Only
    // registered state feeds in_ready; a pop frees its credit one cycle later.
    assign w_used     = {1'b0, r_occ} + {{OW{1'b0}}, r_s1_valid};
    assign in_ready   = (w_used < DEPTH_L);

    assign w_nonempty = (r_occ != '0);
    assign w_accept   = in_valid && in_ready;
    assign w_push     = r_s1_valid;
    assign w_pop      = w_nonempty && out_ready;

    assign w_head     = r_mem[r_rd_ptr];
    assign out_valid  = w_nonempty;
    // Outputs read as zero when empty so stale entries are never visible.
    assign out_sum    = w_nonempty ? w_head[DATA_WIDTH-1:0] : '0;
    assign out_carry  = w_nonempty ? w_head[DATA_WIDTH]     : 1'b0;
    assign out_ovf    = w_nonempty ? w_head[DATA_WIDTH+1]   : 1'b0;
    assign occupancy  = r_occ;
    assign txn_count  = r_txn;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a <= in_a;
                r_s1_b <= in_b;
            end
        end
    end

    // Storage array carries no reset; visibility is governed by occupancy.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_txn    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_txn    <= r_txn + CNT_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OW'(1);
                2'b01:   r_occ <= r_occ - OW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_resp_pipe.sv
// tb/tb_add_resp_pipe.sv - directed bench for add_resp_pipe

module tb_add_resp_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_sum;
    logic       out_carry;
    logic       out_ovf;
    logic [2:0] occupancy;
    logic [15:0] txn_count;

    logic       w_in_valid = 1'b0;
    logic       w_in_ready;
    logic [7:0] w_in_a = 8'h01;
    logic [7:0] w_in_b = 8'h02;
    logic       w_out_valid;
    logic       w_out_ready = 1'b1;
    logic [7:0] w_out_sum;
    logic       w_out_carry;
    logic       w_out_ovf;
    logic [2:0] w_occupancy;
    logic [3:0] w_txn_count;

    add_resp_pipe #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_carry(out_carry), .out_ovf(out_ovf),
        .occupancy(occupancy), .txn_count(txn_count)
    );

    add_resp_pipe #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sum(w_out_sum),
        .out_carry(w_out_carry), .out_ovf(w_out_ovf),
        .occupancy(w_occupancy), .txn_count(w_txn_count)
    );

    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        res_t r;
        s = {1'b0, a} + {1'b0, b};
        r.sum   = s[7:0];
        r.carry = s[8];
        r.ovf   = (a[7] == b[7]) && (s[7] != a[7]);
        return r;
    endfunction

    // Advance one clock. Inputs are stable at the falling edge, so the
    // scoreboard and invariants are evaluated there for the coming edge.
    task automatic step();
        res_t e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("sb_order", 32'({out_sum, out_carry, out_ovf}), 32'(e));
                end
            end
            if (in_valid && in_ready) sb.push_back(model(in_a, in_b));
            check("occ_le_depth", 32'(occupancy <= 3'd4), 32'd1);
            check("credit_le_depth", 32'((4'(occupancy) + 4'(dut.r_s1_valid)) <= 4'd4), 32'd1);
            check("valid_eq_nonempty", 32'(out_valid), 32'(occupancy != 3'd0));
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[10];
    int   acc;
    bit   rdy;

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h03, 8'h04, 8'h07, 1'b0, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h80, 8'h7F, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'h40, 8'h40, 8'h80, 1'b0, 1'b1};
        vecs[7] = '{8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0};
        vecs[8] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
        vecs[9] = '{8'h81, 8'h81, 8'h02, 1'b1, 1'b1};

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_carry", 32'(out_carry), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_txn", 32'(txn_count), 32'd0);

        // Single transactions with exact latency
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_a = vecs[i].a;
            in_b = vecs[i].b;
            in_valid = 1'b1;
            check("vec_in_ready", 32'(in_ready), 32'd1);
            step();
            in_valid = 1'b0;
            check("vec_s1_not_visible", 32'(out_valid), 32'd0);
            step();
            check("vec_out_valid", 32'(out_valid), 32'd1);
            check("vec_sum", 32'(out_sum), 32'(vecs[i].sum));
            check("vec_carry", 32'(out_carry), 32'(vecs[i].carry));
            check("vec_ovf", 32'(out_ovf), 32'(vecs[i].ovf));
            check("vec_occ", 32'(occupancy), 32'd1);
            step();
            check("vec_popped", 32'(out_valid), 32'd0);
            check("vec_txn", 32'(txn_count), 32'(i + 1));
        end

        // Back-to-back pair
        in_valid = 1'b1; in_a = 8'h7F; in_b = 8'h01;
        step();
        in_a = 8'h80; in_b = 8'h80;
        step();
        in_valid = 1'b0;
        check("b2b_first", 32'({out_valid, out_sum, out_carry, out_ovf}), 32'({1'b1, 8'h80, 1'b0, 1'b1}));
        step();
        check("b2b_second", 32'({out_valid, out_sum, out_carry, out_ovf}), 32'({1'b1, 8'h00, 1'b1, 1'b1}));
        step();
        check("b2b_empty", 32'(out_valid), 32'd0);

        // Back-pressure: fill to credit limit, then drain
        out_ready = 1'b0;
        in_a = 8'h00; in_b = 8'h00; in_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            rdy = in_ready;
            step();
            if (rdy) begin
                acc++;
                in_a = in_a + 8'h01;
            end
        end
        in_valid = 1'b0;
        check("bp_accepts", 32'(acc), 32'd4);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_occ_full", 32'(occupancy), 32'd4);
        out_ready = 1'b1;
        check("bp_head0", 32'(out_sum), 32'd0);
        check("bp_ready_before_pop", 32'(in_ready), 32'd0);
        step();
        check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        check("bp_head1", 32'(out_sum), 32'd1);
        step();
        check("bp_head2", 32'(out_sum), 32'd2);
        step();
        check("bp_head3", 32'(out_sum), 32'd3);
        step();
        check("bp_drained", 32'({out_valid, occupancy}), 32'd0);

        // Full-rate streaming with random operands
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("stream_txn_start", 32'(txn_count), 32'd0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_occ", 32'(occupancy), 32'(i >= 2));
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        check("stream_txn", 32'(txn_count), 32'd100);
        check("stream_occ_end", 32'(occupancy), 32'd0);
        check("stream_sb_empty", 32'(sb.size()), 32'd0);

        // Reset with 3 buffered and 1 in the stage register
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = 8'(8'h10 + i);
            in_b = 8'h01;
            check("mid_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        check("mid_occ3", 32'(occupancy), 32'd3);
        check("mid_credit_full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_occ", 32'(occupancy), 32'd0);
        check("mid_in_ready_after", 32'(in_ready), 32'd1);
        check("mid_txn", 32'(txn_count), 32'd0);
        check("mid_sum", 32'(out_sum), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("mid_no_stale", 32'(out_valid), 32'd0);
        end

        // Counter wrap on the 4-bit instance
        check("wrap_txn_start", 32'(w_txn_count), 32'd0);
        w_in_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 40 && acc < 17; c++) begin
            rdy = w_in_ready;
            step();
            if (rdy) acc++;
        end
        w_in_valid = 1'b0;
        step(); step(); step(); step();
        check("wrap_accepts", 32'(acc), 32'd17);
        check("wrap_txn", 32'(w_txn_count), 32'd1);
        check("wrap_occ", 32'(w_occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/add_resp_pipe.md
Name: add_resp_pipe

Overview:
- Responder/DUT end of the adder bench protocol: consumes operand transactions from the add_in interface and produces result transactions on the add_out interface.
- Two-operand adder with:
  - valid/ready input handshake
  - one register stage
  - credit-guarded output FIFO
  - valid/ready output handshake
- Serves as the RTL counterpart driven by the add_in agent and observed by the add_out agent in add_ben.

Parameters:
- DATA_WIDTH, 8, operand and sum width in bits (≥2).
- FIFO_DEPTH, 4, result buffer entries; power of 2, ≥2.
- CNT_WIDTH, 16, width of the completed-transaction counter.

Ports:
- clk  input  1  Single clock. All logic is rising-edge.
- rst  input  1  Synchronous, active-high reset.
- in_valid  input  1  Operand transaction valid.
- in_ready  output  1  Block can accept an operand transaction.
- in_a  input  DATA_WIDTH  Operand A.
- in_b  input  DATA_WIDTH  Operand B.
- out_valid  output  1  Result at FIFO head is valid.
- out_ready  input  1  Consumer accepts the result.
- out_sum  output  DATA_WIDTH  Result, (a+b) mod 2^DATA_WIDTH.
- out_carry  output  1  Unsigned carry-out.
- out_ovf  output  1  Two's-complement signed overflow.
- occupancy  output  $clog2(FIFO_DEPTH)+1  FIFO entry count, excluding the stage register.
- txn_count  output  CNT_WIDTH  Completed output handshakes.

Behaviour:
- Reset (rst=1 at a clk edge): flushes the stage register and FIFO and clears the pointers. Next cycle:
  - in_ready=1, out_valid=0
  - out_sum/out_carry/out_ovf=0
  - occupancy=0, txn_count=0
- Reset mid-operation discards all in-flight and buffered results. No output handshake completes in the reset cycle.
- Input accept: in_valid && in_ready at edge N. The operands are captured into stage register s1 and s1_valid is set.
- Arithmetic, computed from s1 operands:
  - Full sum is DATA_WIDTH+1 bits.
  - out_sum = low DATA_WIDTH bits; out_carry = MSB.
  - out_ovf = (a[MSB]==b[MSB]) && (sum[MSB-1 of low]!=a[MSB]).
- Edge N+1: if s1_valid, the {sum, carry, ovf} word is written into the FIFO.
- Latency: out_valid is high in the cycle following edge N+1 when the FIFO was empty. Throughput is one transaction per clock.
- in_ready = (occupancy + s1_valid) < FIFO_DEPTH. This is registered-state-only, with no combinational path from out_ready or in_valid.
  - A pop in cycle C frees a credit visible from cycle C+1.
  - The s1 write can therefore never find the FIFO full; s1 never stalls.
- out_valid = (occupancy != 0). out_sum/out_carry/out_ovf are the FIFO head. These fields are held stable while out_valid && !out_ready.
- Output handshake: out_valid && out_ready at an edge pops the head and increments txn_count. txn_count wraps from 2^CNT_WIDTH-1 to 0.
- Simultaneous s1 write and pop in the same edge: occupancy unchanged, order preserved.
- FIFO write/read pointers wrap modulo FIFO_DEPTH.
- Strict FIFO order: results emerge in input acceptance order.
- out_ready while out_valid=0 has no effect.
- in_valid while in_ready=0 has no effect. Operands are ignored and not held internally; the source must hold them per protocol.
- Occupancy update per edge:
  - +1 on s1 write only
  - −1 on pop only
  - unchanged when both or neither occur
- Internal state assertions, which the bench also checks:
  - occupancy never exceeds FIFO_DEPTH
  - occupancy + s1_valid never exceeds FIFO_DEPTH
  - no pop when occupancy is 0

Test Plan:
1. Reset, then a single transaction a=8'hFF, b=8'h01 with out_ready=1 → out_valid in the cycle after edge N+1 with out_sum=8'h00, out_carry=1, out_ovf=0; txn_count=1.
2. a=8'h7F, b=8'h01, then a=8'h80, b=8'h80 back-to-back → results in order:
   - {8'h80, carry 0, ovf 1}
   - {8'h00, carry 1, ovf 1}
3. Back-pressure: out_ready=0, in_valid=1 continuously with a=i, b=0 → exactly 4 accepts, then in_ready=0 and occupancy=4. Raising out_ready then drains 0,1,2,3 in order, and in_ready reasserts one cycle after the first pop.
4. Full streaming: in_valid=1 and out_ready=1 for 100 cycles with random operands → one accept and one result per cycle, occupancy steady, scoreboard match, txn_count=100.
5. Reset mid-operation: with 3 results buffered and 1 in s1, assert rst for one edge → next cycle out_valid=0, occupancy=0, in_ready=1, txn_count=0, and no stale results appear afterwards.
6. Counter wrap with CNT_WIDTH=4: 17 transactions → txn_count reads 1.
